regressive_timer: RTL and testbench
===================================

// Module: regressive_timer
// PURPOSE
//  Parametrised down-counting timer: prescales the system clock to a tick rate,
//  then decrements a loadable COUNT_WIDTH count once per tick down to zero.
//  Generalises the fixed 50 MHz one-second tick source into a reusable
//  prescaler + regressive counter, with pause, reload and done signalling.
//  Drives the countdown display/FSM of the regressive counter design.
// PARAMETERS
//  CLK_FREQ_HZ   50_000_000  input clock frequency
//  TICK_HZ       1           tick rate; PRESCALE = CLK_FREQ_HZ/TICK_HZ (integer, >=1)
//  COUNT_WIDTH   8           width of count / load_value
// PORTS
//  clock       in   1        system clock, rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  load        in   1        load count from load_value (highest priority)
//  load_value  in   CW       value loaded on load
//  enable      in   1        level: 1 = run/continue, 0 = pause
//  count       out  CW       current count
//  tick        out  1        1-cycle pulse each prescaled period while counting
//  done        out  1        1-cycle pulse in the cycle after count reaches 0
//  running     out  1        1 while in RUN
//  zero        out  1        level: count == 0
// BEHAVIOUR
//  - Reset (reset_n=0, async, no clock edge needed): count=0, reload_reg=0,
//    prescaler=0, state=IDLE; tick=done=running=0, zero=1.
//  - States: IDLE, RUN, DONE. Registers: count, reload_reg, prescaler
//    ($clog2(PRESCALE) bits, min 1), state, done.
//  - load=1 (any state): count<=load_value, reload_reg<=load_value, prescaler<=0,
//    state<=IDLE, done<=0. Overrides enable and tick on the same edge.
//  - IDLE: enable=1 and count!=0 -> RUN, prescaler=0. count==0: stay IDLE.
//  - RUN, enable=1: prescaler increments; tick = (prescaler==PRESCALE-1)
//    (combinational from registers); on a tick edge prescaler wraps to 0 and
//    count decrements. First tick PRESCALE cycles after entering RUN.
//  - RUN, enable=0: prescaler and count hold, tick=0; state stays RUN
//    (running=1). Resuming continues the partial period exactly.
//  - Tick edge with count==1: count<=0, done<=1 for exactly one cycle,
//    state<=DONE.
//  - DONE: count holds 0, enable ignored; leaves only via load or reset.
//  - done is registered; it is never asserted on load or reset.
//  - count never wraps below 0; no decrement occurs at count==0.
//  - PRESCALE==1: tick high every enabled RUN cycle.
// CONFIGURATION
//  AUTO_RELOAD_EN defined: on the tick edge with count==1, count<=reload_reg,
//    done pulses, state stays RUN, prescaler wraps normally (periodic timer,
//    no lost cycles). DONE is unreachable.
//  Not defined: one-shot behaviour as above (RUN -> DONE).
// TESTING  (CLK_FREQ_HZ=10, TICK_HZ=1, COUNT_WIDTH=4, PRESCALE=10)
//  1 reset_n=0 mid-run, no clock edge -> count=0, running=0, zero=1 at once.
//  2 load 3, enable=1 -> ticks 10/20/30 cycles after RUN entry; count 3,2,1,0;
//    done=1 one cycle after the 3rd tick edge; running=0, count stays 0.
//  3 load 3, run 4 cycles, enable=0 for 7 cycles -> 1st tick at cycle 17; count=2.
//  4 RUN with count=2, load 5 -> count=5, IDLE, prescaler=0, done=0;
//    re-enable -> tick 10 cycles later.
//  5 load 0, enable=1 -> stays IDLE, no tick, no done, zero=1.
//  6 AUTO_RELOAD_EN, load 2, enable=1 -> count 2,1,2,1...; done every 20 cycles;
//    running stays 1.

Source files
------------

// File: rtl/regressive_timer_if.sv
//------------------------------------------------------------------------------
// regressive_timer_if : control/status bundle of the regressive timer
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface regressive_timer_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   load;
  logic [COUNT_WIDTH-1:0] load_value;
  logic                   enable;
  logic [COUNT_WIDTH-1:0] count;
  logic                   tick;
  logic                   done;
  logic                   running;
  logic                   zero;

  modport master (
    output load, load_value, enable,
    input  count, tick, done, running, zero
  );

  modport slave (
    input  load, load_value, enable,
    output count, tick, done, running, zero
  );
endinterface

`default_nettype wire

// File: rtl/regressive_timer.sv
//------------------------------------------------------------------------------
// regressive_timer : prescaler + loadable down-counter with pause/reload/done.
// Optional AUTO_RELOAD_EN makes it a periodic timer.  Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regressive_timer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  regressive_timer_if.slave tmr
);

  localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]        PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [PS_W-1:0]        prescale_q;
  logic                   done_q;
  logic                   tick_d;
`ifdef AUTO_RELOAD_EN
  logic [COUNT_WIDTH-1:0] reload_q;
`endif

  // Tick is decoded from registered state so a pause drops it in the same cycle.
  assign tick_d = (state_q == S_RUN) && tmr.enable && (prescale_q == PS_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      prescale_q <= '0;
      done_q     <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (tmr.load) begin
        state_q    <= S_IDLE;
        count_q    <= tmr.load_value;
        prescale_q <= '0;
`ifdef AUTO_RELOAD_EN
        reload_q   <= tmr.load_value;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (tmr.enable && (count_q != '0)) begin
              state_q    <= S_RUN;
              prescale_q <= '0;
            end
          end
          S_RUN: begin
            if (tmr.enable) begin
              if (tick_d) begin
                prescale_q <= '0;
                if (count_q == COUNT_ONE) begin
                  done_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
                  count_q <= reload_q;
`else
                  count_q <= '0;
                  state_q <= S_DONE;
`endif
                end else begin
                  count_q <= count_q - COUNT_ONE;
                end
              end else begin
                prescale_q <= prescale_q + PS_W'(1);
              end
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tmr.count   = count_q;
  assign tmr.tick    = tick_d;
  assign tmr.done    = done_q;
  assign tmr.running = (state_q == S_RUN);
  assign tmr.zero    = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_regressive_timer.sv
//------------------------------------------------------------------------------
// tb_regressive_timer : scoreboard bench with a cycle-level reference model.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regressive_timer;

  localparam int P  = 10;
  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] count;
    logic          tick;
    logic          done;
    logic          running;
    logic          zero;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regressive_timer_if #(.COUNT_WIDTH(CW)) bus ();

  regressive_timer #(
    .CLK_FREQ_HZ (10),
    .TICK_HZ     (1),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .tmr     (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb[$];

  // Reference model: 0 = waiting, 1 = counting, 2 = finished
  int m_cnt     = 0;
  int m_reload  = 0;
  int m_elapsed = 0;
  int m_mode    = 0;

  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_elapsed = 0; m_mode = 0;
  endtask

  // Advance the model across one rising edge and queue the outputs seen after it.
  task automatic model_edge(input logic ld, input int lv, input logic en, input logic rn);
    obs_t e;
    logic dn;
    dn = 1'b0;
    if (!rn) begin
      model_reset();
    end else if (ld) begin
      m_cnt = lv; m_reload = lv; m_elapsed = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (en && m_cnt > 0) begin
        m_mode = 1; m_elapsed = 0;
      end
    end else if (m_mode == 1 && en) begin
      if (m_elapsed == P - 1) begin
        m_elapsed = 0;
        if (m_cnt == 1) begin
          dn = 1'b1;
`ifdef AUTO_RELOAD_EN
          m_cnt = m_reload;
`else
          m_cnt  = 0;
          m_mode = 2;
`endif
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else begin
        m_elapsed = m_elapsed + 1;
      end
    end
    e.count   = CW'(m_cnt);
    e.tick    = (m_mode == 1) && en && (m_elapsed == P - 1);
    e.done    = dn;
    e.running = (m_mode == 1);
    e.zero    = (m_cnt == 0);
    sb.push_back(e);
  endtask

  task automatic step(input logic ld, input int lv, input logic en, input logic rn);
    @(negedge clk);
    bus.load       = ld;
    bus.load_value = CW'(lv);
    bus.enable     = en;
    rst_n          = rn;
    model_edge(ld, lv, en, rn);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: compares every observed cycle against the queued expectation.
  obs_t got_o, exp_o;
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_o = sb.pop_front();
      got_o = {bus.count, bus.tick, bus.done, bus.running, bus.zero};
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL outputs @%0t: got cnt=%0d tick=%b done=%b run=%b zero=%b, expected cnt=%0d tick=%b done=%b run=%b zero=%b",
                 $time, got_o.count, got_o.tick, got_o.done, got_o.running, got_o.zero,
                 exp_o.count, exp_o.tick, exp_o.done, exp_o.running, exp_o.zero);
      end
    end
  end

  initial begin
    int n;
    bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0;

    // Reset state
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Full one-shot countdown from 3: done appears 31 enabled edges after entry
    step(1, 3, 0, 1);
    n = 0;
    while (n < 200) begin
      step(0, 0, 1, 1);
      n++;
      @(posedge clk); #2;
      if (bus.done) break;
    end
`ifdef AUTO_RELOAD_EN
    check("done_latency", n, 31);
`else
    check("done_latency", n, 31);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
`endif

    // Pause partway through the first period
    step(1, 3, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
    n = 0;
    while (n < 50) begin
      step(0, 0, 1, 1);
      n++;
      @(posedge clk); #2;
      if (bus.count == CW'(2)) break;
    end
    check("resume_steps", n, 6);

    // Load during RUN overrides enable, then a fresh full period
    step(0, 0, 1, 1);
    step(1, 5, 1, 1);
    for (int i = 0; i < 13; i++) step(0, 0, 1, 1);

    // Load of zero never starts
    step(1, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 1);

    // Asynchronous reset mid-run, observed without a clock edge
    step(1, 6, 0, 1);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_count", int'(bus.count), 0);
    check("async_running", int'(bus.running), 0);
    check("async_zero", int'(bus.zero), 1);
    check("async_tick", int'(bus.tick), 0);
    model_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic ld, en, rn;
      ld = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 80);
      rn = ($urandom_range(0, 999) >= 3);
      step(ld, int'($urandom_range(0, 15)), en, rn);
    end

    step(0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
